// File: rtl/i2s_pkg.sv
// Shared widths and FSM state encoding for the I2S receive path.
package i2s_pkg;

  localparam int unsigned I2S_WORD_W  = 16;
  localparam int unsigned I2S_FRAME_W = 2 * I2S_WORD_W;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LEFT  = 2'd1,
    ST_RIGHT = 2'd2
  } i2si_state_e;

  function automatic int unsigned frame_width(input int unsigned word_w);
    return 2 * word_w;
  endfunction

endpackage

// File: rtl/i2s_deserializer_if.sv
// Downstream frame handshake: producer raises i2si_rts, consumer answers with i2si_rtr.
interface i2s_deserializer_if #(
  parameter int unsigned FRAME_W = i2s_pkg::I2S_FRAME_W
);

  logic               i2si_rts;
  logic               i2si_rtr;
  logic [FRAME_W-1:0] i2si_data;

  modport master (
    output i2si_rts,
    output i2si_data,
    input  i2si_rtr
  );

  modport slave (
    input  i2si_rts,
    input  i2si_data,
    output i2si_rtr
  );

endinterface

// File: rtl/i2si_word_shifter.sv
// MSB-first word assembler: keeps the first WORD_W bits of a word, zero-fills the rest.
module i2si_word_shifter
  import i2s_pkg::*;
#(
  parameter int unsigned WORD_W = I2S_WORD_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear_i,
  input  logic              shift_i,
  input  logic              bit_i,
  output logic [WORD_W-1:0] word_o
);

  localparam int unsigned           CNT_W    = $clog2(WORD_W + 1);
  localparam logic [CNT_W-1:0]      CNT_FULL = CNT_W'(WORD_W);

  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [WORD_W-1:0] sh_q, sh_d;
  logic [WORD_W-1:0] word;
  logic              take;

  assign take = shift_i && (cnt_q != CNT_FULL);

  // word_o already includes the bit being shifted this cycle, so the
  // owner can capture a completed word in the same cycle as its last bit.
  always_comb begin
    word = sh_q;
    for (int unsigned i = 0; i < WORD_W; i++) begin
      if (take && (32'(cnt_q) == WORD_W - 1 - i)) begin
        word[i] = bit_i;
      end
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    sh_d  = word;
    if (clear_i) begin
      cnt_d = '0;
      sh_d  = '0;
    end else if (take) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      sh_q  <= '0;
    end else begin
      cnt_q <= cnt_d;
      sh_q  <= sh_d;
    end
  end

  assign word_o = word;

endmodule

// File: rtl/i2s_deserializer.sv
// I2S receiver: assembles left/right words into {left,right} frames with an rts/rtr handshake.
// Optional sticky overrun status is built when I2SI_OVERRUN_STATUS_EN is defined.
module i2s_deserializer
  import i2s_pkg::*;
#(
  parameter int unsigned WORD_W = I2S_WORD_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               sck_transition,
  input  logic               i2si_ws,
  input  logic               i2si_sd,
  input  logic               rf_i2si_en,
  output logic               ro_overrun,
  input  logic               trig_overrun,
  i2s_deserializer_if.master dn
);

  localparam int unsigned FRAME_W = frame_width(WORD_W);

  i2si_state_e        state_q, state_d;
  logic               ws_prev_q, ws_prev_d;
  logic               ws_rise, ws_fall;
  logic               shift_en, shift_clear, left_latch, frame_done;
  logic [WORD_W-1:0]  word;
  logic [WORD_W-1:0]  left_q, left_d;
  logic [FRAME_W-1:0] data_q, data_d;
  logic               rts_q, rts_d;
  logic               ovr_set;

  assign ws_prev_d = sck_transition ? i2si_ws : ws_prev_q;
  assign ws_rise   = sck_transition & ~ws_prev_q &  i2si_ws;
  assign ws_fall   = sck_transition &  ws_prev_q & ~i2si_ws;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (!rf_i2si_en) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:  if (ws_fall) state_d = ST_LEFT;
        ST_LEFT:  if (ws_rise) state_d = ST_RIGHT;
        ST_RIGHT: if (ws_fall) state_d = ST_LEFT;
        default:  state_d = ST_IDLE;
      endcase
    end
  end

  // The bit sampled on a ws edge still belongs to the word being closed;
  // the shifter is cleared after it so the next sck starts the new MSB.
  always_comb begin
    shift_en    = 1'b0;
    shift_clear = 1'b1;
    left_latch  = 1'b0;
    frame_done  = 1'b0;
    if (rf_i2si_en) begin
      case (state_q)
        ST_LEFT: begin
          shift_en    = sck_transition;
          shift_clear = ws_rise;
          left_latch  = ws_rise;
        end
        ST_RIGHT: begin
          shift_en    = sck_transition;
          shift_clear = ws_fall;
          frame_done  = ws_fall;
        end
        default: ;
      endcase
    end
  end

  i2si_word_shifter #(
    .WORD_W (WORD_W)
  ) u_shifter (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear_i (shift_clear),
    .shift_i (shift_en),
    .bit_i   (i2si_sd),
    .word_o  (word)
  );

  assign left_d = left_latch ? word : left_q;

  always_comb begin
    data_d  = data_q;
    rts_d   = rts_q;
    ovr_set = 1'b0;
    if (frame_done) begin
      if (!rts_q || dn.i2si_rtr) begin
        data_d = {left_q, word};
        rts_d  = 1'b1;
      end else begin
        ovr_set = 1'b1;
      end
    end else if (rts_q && dn.i2si_rtr) begin
      rts_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ws_prev_q <= 1'b1;
      left_q    <= '0;
      data_q    <= '0;
      rts_q     <= 1'b0;
    end else begin
      ws_prev_q <= ws_prev_d;
      left_q    <= left_d;
      data_q    <= data_d;
      rts_q     <= rts_d;
    end
  end

`ifdef I2SI_OVERRUN_STATUS_EN
  logic ovr_q, ovr_d;

  always_comb begin
    ovr_d = ovr_q;
    if (ovr_set)           ovr_d = 1'b1;
    else if (trig_overrun) ovr_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ovr_q <= 1'b0;
    else        ovr_q <= ovr_d;
  end

  assign ro_overrun = ovr_q;
`else
  logic unused_ovr;
  assign unused_ovr = ovr_set ^ trig_overrun;
  assign ro_overrun = 1'b0;
`endif

  assign dn.i2si_rts  = rts_q;
  assign dn.i2si_data = data_q;

endmodule
